// File: rtl/adder_input_conditioner.sv
// adder_input_conditioner
// Synchronizes the raw slider switches and synchronizes plus debounces the
// two active-low push-buttons that feed the lab 4 adder. Each button has its
// own independent channel. The channel gives a clean active-high level and a
// single-cycle strobe when a press is accepted, so that one physical press
// produces exactly one load or one add.

module adder_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        LoadB_n,
  input  logic        Run_n,
  input  logic [15:0] SW,
  output logic [15:0] SW_sync,
  output logic        LoadB_held,
  output logic        Run_held,
  output logic        LoadB_pulse,
  output logic        Run_pulse
);

  // Channel 0 is LoadB and channel 1 is Run. Both use identical logic.
  localparam int                   NUM_BTN  = 2;
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [NUM_BTN-1:0]   btn_raw_s;
  logic [NUM_BTN-1:0]   btn_s1_r;
  logic [NUM_BTN-1:0]   btn_s2_r;
  logic [NUM_BTN-1:0]   stable_r;
  logic [NUM_BTN-1:0]   stable_nxt_s;
  logic [NUM_BTN-1:0]   pulse_r;
  logic [NUM_BTN-1:0]   pulse_nxt_s;
  logic [CNT_WIDTH-1:0] cnt_r     [NUM_BTN];
  logic [CNT_WIDTH-1:0] cnt_nxt_s [NUM_BTN];

  logic [15:0]          sw_s1_r;
  logic [15:0]          sw_s2_r;

  assign btn_raw_s = {Run_n, LoadB_n};

  // Debounce decision per button. Any sample that agrees with the accepted
  // state restarts the count. Only an unbroken run of DEBOUNCE_CYCLES
  // disagreeing samples moves the accepted state. The count stops at
  // CNT_MAX and is never allowed to wrap.
  always_comb begin
    for (int i = 0; i < NUM_BTN; i++) begin
      stable_nxt_s[i] = stable_r[i];
      cnt_nxt_s[i]    = CNT_ZERO;
      if (btn_s2_r[i] == stable_r[i]) begin
        cnt_nxt_s[i] = CNT_ZERO;
      end else if (cnt_r[i] == CNT_MAX) begin
        stable_nxt_s[i] = btn_s2_r[i];
        cnt_nxt_s[i]    = CNT_ZERO;
      end else begin
        cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
      end
      // Only an accepted press (released to pressed) strobes. A release
      // never does.
      pulse_nxt_s[i] = stable_r[i] & ~stable_nxt_s[i];
    end
  end

  // Button synchronizers, debounce state and press strobes. Reset returns
  // every channel to the released state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      btn_s1_r <= {NUM_BTN{1'b1}};
      btn_s2_r <= {NUM_BTN{1'b1}};
      stable_r <= {NUM_BTN{1'b1}};
      pulse_r  <= {NUM_BTN{1'b0}};
      for (int i = 0; i < NUM_BTN; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
    end else begin
      btn_s1_r <= btn_raw_s;
      btn_s2_r <= btn_s1_r;
      stable_r <= stable_nxt_s;
      pulse_r  <= pulse_nxt_s;
      for (int i = 0; i < NUM_BTN; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
      end
    end
  end

  // Two-flop synchronizer for the slider switches. The switches are only
  // synchronized, not debounced.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sw_s1_r <= 16'h0000;
      sw_s2_r <= 16'h0000;
    end else begin
      sw_s1_r <= SW;
      sw_s2_r <= sw_s1_r;
    end
  end

  assign SW_sync     = sw_s2_r;
  assign LoadB_held  = ~stable_r[0];
  assign Run_held    = ~stable_r[1];
  assign LoadB_pulse = pulse_r[0];
  assign Run_pulse   = pulse_r[1];

endmodule

// File: doc/adder_input_conditioner.md
# adder_input_conditioner

Input-conditioning stage directly upstream of the lab 4 adder top level. It takes the raw, asynchronous, active-low push-buttons (LoadB, Run) and the 16 slider switches, then synchronizes and debounces them. The adder receives clean level signals and single-cycle press pulses, so one physical press triggers exactly one load or one addition.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 16: consecutive stable synchronized samples required to accept a button change. Use 16 in simulation and 500000 on the board. Legal range ≥ 2.
- CNT_WIDTH, default $clog2(DEBOUNCE_CYCLES): debounce counter width.

Ports:
- Clk  input  1  system clock, 50 MHz on board.
- Reset  input  1  synchronous, active-high reset.
- LoadB_n  input  1  raw LoadB button, active-low (0 = pressed), asynchronous.
- Run_n  input  1  raw Run button, active-low, asynchronous.
- SW  input  16  raw slider switches, asynchronous.
- SW_sync  output  16  two-flop synchronized copy of SW.
- LoadB_held  output  1  debounced LoadB level, active-high (1 = pressed).
- Run_held  output  1  debounced Run level, active-high.
- LoadB_pulse  output  1  one-cycle strobe when a LoadB press is accepted.
- Run_pulse  output  1  one-cycle strobe when a Run press is accepted.

## Operation
- Each button has an identical, independent channel:
  - Two-flop synchronizer: s1 then s2.
  - Debounced state register `stable`, holding raw polarity.
  - Counter `cnt` of width CNT_WIDTH.
- Each rising edge of Clk:
  - If s2 == stable, cnt is set to 0.
  - Else if cnt == DEBOUNCE_CYCLES-1, stable is set to s2 and cnt is set to 0.
  - Else cnt is incremented by 1.
- Any single sample equal to `stable` (a bounce) restarts the count. cnt never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- `*_held` = ~stable, driven directly from the register.
- `*_pulse` is registered. It is set to 1 on the edge where stable changes from 1 to 0, and cleared on every other edge. A release (0 to 1) never produces a pulse.
- A pulse is 1 cycle wide regardless of how long the button is held. Another pulse requires a debounced release followed by a new debounced press.
- The channels are fully independent. Simultaneous presses that are accepted on the same edge produce both pulses in the same cycle, with no priority between them.
- SW passes through a two-flop synchronizer per bit and is not debounced. SW_sync is valid two edges after SW changes.
- Reset (synchronous, active-high) sets:
  - s1, s2, stable to 1 (released);
  - cnt to 0;
  - both pulses to 0;
  - both held outputs to 0;
  - both SW synchronizer stages to 0.
- Reset takes priority over all other updates.

## Timing
- Reset values: SW_sync = 16'h0000; LoadB_held = Run_held = LoadB_pulse = Run_pulse = 0.
- Press latency, with N = DEBOUNCE_CYCLES and edge 0 the first edge that samples the button low:
  - s2 is low after edge 1.
  - cnt reaches N-1 after edge N.
  - stable flips at edge N+1.
  - `*_held` and `*_pulse` go high after edge N+1, and the pulse drops after edge N+2.
  - Total: N+2 edges.
- Release latency: `*_held` falls N+2 edges after the first high sample, with no pulse.
- Reset mid-debounce: the count is discarded. If the button is still pressed when Reset deasserts, a complete new N+2 debounce runs, measured from the first edge after Reset deasserts, and produces exactly one pulse.
- Reset asserted while a pulse is high: the pulse is 0 after that edge.
- A button held low through Reset with an already-accepted press:
  - Reset clears stable to 1.
  - One new pulse is produced after re-debouncing.
  - This is the required behaviour.

## Test plan
- Reset: assert Reset for 2 cycles with Run_n = LoadB_n = 1 and SW = 16'hFFFF. Required: all outputs 0 during reset, and SW_sync = 16'hFFFF two edges after release.
- Clean press (N=4): drive Run_n low for 20 cycles. Required:
  - Run_pulse high exactly 1 cycle, after edge 5 relative to the first low sample (edge 0).
  - Run_held high from the same point until 6 edges after Run_n returns high.
  - No pulse on release.
- Bounce (N=4): drive Run_n with the pattern 0,0,0,1,0,0,0,0,0,0. Required:
  - No pulse from the first 3-sample burst.
  - One pulse, timed from the 0 that follows the 1.
  - Total pulse count = 1.
- Switch path: SW = 16'h000D, then LoadB press, then SW = 16'h0001, then Run press. Required:
  - SW_sync = 16'h000D two edges after the first change.
  - LoadB_pulse fires while SW_sync = 16'h000D.
  - SW_sync = 16'h0001 before Run_pulse fires.
- Reset mid-debounce (N=4): press Run_n, assert Reset at cnt = 2 for 1 cycle, and keep Run_n low. Required: no pulse before reset; exactly one pulse 6 edges after Reset deasserts.
- Simultaneous presses: drive LoadB_n and Run_n low on the same cycle. Required: LoadB_pulse and Run_pulse are both high in the same single cycle.
